// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
// Synchronises the raw PS/2 clock and data pins into the system clock domain.
// Debounces the PS/2 clock, then deserialises 11-bit frames (start, 8 data
// bits LSB-first, odd parity, stop). Each valid scancode is presented on
// ps2_data with a one-cycle ps2_hit strobe. Parity errors, stop-bit errors
// and timeouts produce a one-cycle ps2_err strobe instead.
//
// Ports:
//   clock    in   system clock; all logic runs on posedge
//   reset    in   synchronous, active-high reset
//   ps2_clk  in   raw PS/2 clock pin (asynchronous)
//   ps2_dat  in   raw PS/2 data pin (asynchronous)
//   ps2_data out  last valid scancode, held until the next valid frame
//   ps2_hit  out  one-cycle strobe; ps2_data is valid on the same cycle
//   ps2_err  out  one-cycle strobe on a parity, stop-bit or timeout error
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a filtered falling edge)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and parity, then reporting hit or err
module ps2_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 25000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] ps2_data,
   output logic       ps2_hit,
   output logic       ps2_err
);

   localparam int             TW      = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0]     FLT_END = 8'(FILTER_LEN - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   logic          clk_s1, sync_clk;
   logic          dat_s1, sync_dat;
   logic          filt_clk, filt_d1;
   logic [7:0]    filt_cnt;
   logic          fall;

   state_t        state, state_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [2:0]    bitcnt, bitcnt_nxt;
   logic          par, par_nxt;
   logic [TW-1:0] tocnt, tocnt_nxt;
   logic [7:0]    data_nxt;
   logic          hit_nxt, err_nxt;

   // Synchronisers reset to the idle (high) bus level so leaving reset
   // never looks like a falling edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1   <= 1'b1;
         sync_clk <= 1'b1;
         dat_s1   <= 1'b1;
         sync_dat <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         sync_clk <= clk_s1;
         dat_s1   <= ps2_dat;
         sync_dat <= dat_s1;
      end
   end

   // The filtered clock follows sync_clk only after FILTER_LEN consecutive
   // disagreeing samples; any shorter disagreement is ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_d1  <= 1'b1;
         filt_cnt <= 8'd0;
      end else begin
         filt_d1 <= filt_clk;
         if (sync_clk != filt_clk) begin
            if (filt_cnt == FLT_END) begin
               filt_clk <= sync_clk;
               filt_cnt <= 8'd0;
            end else begin
               filt_cnt <= filt_cnt + 8'd1;
            end
         end else begin
            filt_cnt <= 8'd0;
         end
      end
   end

   assign fall = filt_d1 & ~filt_clk;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= 8'h00;
         bitcnt   <= 3'd0;
         par      <= 1'b0;
         tocnt    <= '0;
         ps2_data <= 8'h00;
         ps2_hit  <= 1'b0;
         ps2_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bitcnt   <= bitcnt_nxt;
         par      <= par_nxt;
         tocnt    <= tocnt_nxt;
         ps2_data <= data_nxt;
         ps2_hit  <= hit_nxt;
         ps2_err  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      bitcnt_nxt = bitcnt;
      par_nxt    = par;
      tocnt_nxt  = tocnt;
      data_nxt   = ps2_data;
      hit_nxt    = 1'b0;
      err_nxt    = 1'b0;

      if (state == IDLE) begin
         tocnt_nxt = '0;
         if (fall && !sync_dat) begin
            state_nxt  = DATA;
            bitcnt_nxt = 3'd0;
         end
      end else if (fall) begin
         // A fall on the timeout-reaching cycle still counts: the frame goes on.
         tocnt_nxt = '0;
         case (state)
            DATA: begin
               shreg_nxt  = {sync_dat, shreg[7:1]};
               bitcnt_nxt = bitcnt + 3'd1;
               if (bitcnt == 3'd7)
                  state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = sync_dat;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (sync_dat && (^{shreg, par})) begin
                  hit_nxt  = 1'b1;
                  data_nxt = shreg;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else if (tocnt == TO_LAST) begin
         state_nxt = IDLE;
         tocnt_nxt = '0;
         err_nxt   = 1'b1;
      end else begin
         tocnt_nxt = tocnt + 1'b1;
      end
   end

endmodule
